i2c_slave_rx: RTL and testbench

I2C slave front end that decodes bus traffic on the `ui_in` SDA/SCL pins into a byte stream for the SPI master stage, and returns SPI read-back bytes to the I2C master. It sits directly upstream of the SPI master inside the I2C-to-SPI wrapper:
- Written data bytes leave on a valid/ready byte port.
- Read requests pull bytes from a second valid/ready port fed by the SPI side.
- All logic runs on the system clock; SCL is oversampled, never used as a clock.

---
 rtl/i2c_slave_rx.sv | 182 ++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// I2C slave front end: oversamples SCL/SDA on the system clock, ACKs SLAVE_ADDR,
// delivers written bytes on a valid/ready port and returns read bytes from a second one.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       i2c_wb_clk_i,
  input  logic       i2c_wb_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_first_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       overrun_o
);

  // Handshakes: a byte moves on any cycle where valid & ready are both high.
  // rx_valid_o holds its byte until taken; tx_ready_o is a one-cycle pulse.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_e;

  state_e     state_q;
  logic       scl_m_q, scl_s_q, scl_h_q;
  logic       sda_m_q, sda_s_q, sda_h_q;
  logic [7:0] shreg_q;
  logic [2:0] cnt_q;
  logic       phase_q, rw_q, ack_q, first_q;
  logic       sda_oe_q, rx_valid_q, rx_first_q, tx_ready_q, busy_q, overrun_q;
  logic [7:0] rx_data_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte_d, load_byte_d;

  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      scl_m_q <= 1'b1; scl_s_q <= 1'b1; scl_h_q <= 1'b1;
      sda_m_q <= 1'b1; sda_s_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= scl_i;   scl_s_q <= scl_m_q; scl_h_q <= scl_s_q;
      sda_m_q <= sda_i;   sda_s_q <= sda_m_q; sda_h_q <= sda_s_q;
    end
  end

  assign scl_rise    = scl_s_q & ~scl_h_q;
  assign scl_fall    = ~scl_s_q & scl_h_q;
  assign start_det   = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
  assign stop_det    = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;
  assign rx_byte_d   = {shreg_q[6:0], sda_s_q};
  // With nothing offered by the SPI side the master reads all ones (released bus).
  assign load_byte_d = tx_valid_i ? tx_data_i : 8'hFF;

  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'h00;
      cnt_q      <= 3'd0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd0;
        phase_q  <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADDR: if (scl_rise) begin
            shreg_q <= rx_byte_d;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_q    <= sda_s_q;
              phase_q <= 1'b0;
              state_q <= (shreg_q[6:0] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= 1'b1;
              phase_q  <= 1'b1;
            end else if (!rw_q) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 3'd0;
              first_q  <= 1'b1;
              state_q  <= S_WR_DATA;
            end else begin
              shreg_q    <= load_byte_d;
              tx_ready_q <= tx_valid_i;
              sda_oe_q   <= ~load_byte_d[7];
              cnt_q      <= 3'd0;
              state_q    <= S_RD_DATA;
            end
          end
          S_WR_DATA: if (scl_rise) begin
            shreg_q <= rx_byte_d;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              first_q <= 1'b0;
              phase_q <= 1'b0;
              state_q <= S_WR_ACK;
              if (!rx_valid_q) begin
                rx_data_q  <= rx_byte_d;
                rx_valid_q <= 1'b1;
                rx_first_q <= first_q;
                ack_q      <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
                ack_q     <= 1'b0;
              end
            end
          end
          S_WR_ACK: if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= ack_q;
              phase_q  <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 3'd0;
              state_q  <= S_WR_DATA;
            end
          end
          S_RD_DATA: if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_q <= 1'b0;
              phase_q  <= 1'b0;
              state_q  <= S_RD_ACK;
            end else begin
              shreg_q  <= {shreg_q[6:0], 1'b0};
              sda_oe_q <= ~shreg_q[6];
              cnt_q    <= cnt_q + 3'd1;
            end
          end
          S_RD_ACK: begin
            if (!phase_q && scl_rise) begin
              if (sda_s_q) state_q <= S_IGNORE;
              else         phase_q <= 1'b1;
            end else if (phase_q && scl_fall) begin
              shreg_q    <= load_byte_d;
              tx_ready_q <= tx_valid_i;
              sda_oe_q   <= ~load_byte_d[7];
              cnt_q      <= 3'd0;
              state_q    <= S_RD_DATA;
            end
          end
          S_IGNORE: sda_oe_q <= 1'b0;
          default:  state_q  <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_first_o = rx_first_q;
  assign tx_ready_o = tx_ready_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master tasks on an open-drain SDA model,
// scoreboards for written and read bytes, and monitors for handshake pulses.
module tb_i2c_slave_rx;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       rx_ready, tx_valid;
  logic [7:0] tx_data;
  logic       sda_oe, rx_valid, rx_first, tx_ready, busy, overrun;
  logic [7:0] rx_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cycles = 0, oe_cycles = 0, txr_cycles = 0;
  logic [8:0] exp_q[$];
  logic [7:0] rd_exp_q[$];

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'h42)) dut (
    .i2c_wb_clk_i(clk), .i2c_wb_rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe_o(sda_oe), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_first_o(rx_first), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .busy_o(busy), .overrun_o(overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cycles++;
      if (sda_oe)   oe_cycles++;
      if (tx_ready) txr_cycles++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check_eq("rx_queue_size", exp_q.size(), 1);
        else check_eq("rx_byte", {23'b0, rx_first, rx_data}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;  wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    s = sda_bus; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic s;
    logic [7:0] t;
    t = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      t[i] = s;
    end
    clock_bit(~ack, s);
    b = t;
  endtask

  initial begin
    logic ack, s;
    logic [7:0] b;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_first", rx_first, 0);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    rst = 1'b0;
    wait_clk(4);

    // Basic write
    valid_cycles = 0;
    i2c_start();
    write_byte({7'h42, 1'b0}, ack); check_eq("t1_addr_ack", ack, 1);
    exp_q.push_back({1'b1, 8'hA5});
    write_byte(8'hA5, ack); check_eq("t1_data_ack", ack, 1);
    check_eq("t1_valid_cycles", valid_cycles, 1);
    check_eq("t1_busy_before_stop", busy, 1);
    i2c_stop();
    check_eq("t1_busy_after_stop", busy, 0);

    // Address mismatch
    valid_cycles = 0; oe_cycles = 0;
    i2c_start();
    write_byte({7'h43, 1'b0}, ack); check_eq("t2_addr_nack", ack, 0);
    write_byte(8'h11, ack);         check_eq("t2_data_nack", ack, 0);
    i2c_stop();
    check_eq("t2_oe_cycles", oe_cycles, 0);
    check_eq("t2_valid_cycles", valid_cycles, 0);

    // Overrun
    rx_ready = 1'b0;
    i2c_start();
    write_byte({7'h42, 1'b0}, ack); check_eq("t3_addr_ack", ack, 1);
    write_byte(8'h01, ack);         check_eq("t3_b1_ack", ack, 1);
    write_byte(8'h02, ack);         check_eq("t3_b2_nack", ack, 0);
    check_eq("t3_overrun", overrun, 1);
    check_eq("t3_data_held", rx_data, 8'h01);
    check_eq("t3_valid_held", rx_valid, 1);
    i2c_stop();
    check_eq("t3_valid_after_stop", rx_valid, 1);
    exp_q.push_back({1'b1, 8'h01});
    rx_ready = 1'b1;
    wait_clk(4);
    check_eq("t3_valid_consumed", rx_valid, 0);

    // Read: supplied byte, then an empty SPI side
    txr_cycles = 0;
    tx_valid = 1'b1; tx_data = 8'h3C;
    i2c_start();
    write_byte({7'h42, 1'b1}, ack); check_eq("t4_addr_ack", ack, 1);
    tx_valid = 1'b0;
    rd_exp_q.push_back(8'h3C);
    rd_exp_q.push_back(8'hFF);
    read_byte(1'b1, b); check_eq("t4_rd_byte0", b, rd_exp_q.pop_front());
    read_byte(1'b0, b); check_eq("t4_rd_byte1", b, rd_exp_q.pop_front());
    i2c_stop();
    check_eq("t4_tx_ready_pulses", txr_cycles, 1);
    check_eq("t4_busy_idle", busy, 0);
    check_eq("t4_sda_released", sda_oe, 0);

    // Repeated START: write then read
    txr_cycles = 0;
    i2c_start();
    write_byte({7'h42, 1'b0}, ack); check_eq("t5_waddr_ack", ack, 1);
    exp_q.push_back({1'b1, 8'h10});
    write_byte(8'h10, ack); check_eq("t5_data_ack", ack, 1);
    tx_valid = 1'b1; tx_data = 8'h5A;
    i2c_start();
    write_byte({7'h42, 1'b1}, ack); check_eq("t5_raddr_ack", ack, 1);
    tx_valid = 1'b0;
    rd_exp_q.push_back(8'h5A);
    read_byte(1'b0, b); check_eq("t5_rd_byte", b, rd_exp_q.pop_front());
    i2c_stop();
    check_eq("t5_tx_ready_pulses", txr_cycles, 1);

    // Reset mid-byte with a pending byte
    rx_ready = 1'b0;
    i2c_start();
    write_byte({7'h42, 1'b0}, ack); check_eq("t6_addr_ack", ack, 1);
    write_byte(8'h77, ack);         check_eq("t6_b_ack", ack, 1);
    check_eq("t6_pending", rx_valid, 1);
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    check_eq("t6_busy_mid", busy, 1);
    rst = 1'b1;
    wait_clk(1);
    check_eq("t6_rst_rx_valid", rx_valid, 0);
    check_eq("t6_rst_sda_oe", sda_oe, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_overrun", overrun, 0);
    check_eq("t6_rst_rx_data", rx_data, 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
    i2c_start();
    write_byte({7'h42, 1'b0}, ack); check_eq("t6_re_addr_ack", ack, 1);
    exp_q.push_back({1'b1, 8'hC3});
    write_byte(8'hC3, ack); check_eq("t6_re_data_ack", ack, 1);
    i2c_stop();
    wait_clk(4);

    check_eq("rx_queue_drained", exp_q.size(), 0);
    check_eq("rd_queue_drained", rd_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
